// File: rtl/wordle_scorer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wordle_scorer_pkg
// Description : Shared word geometry, colour codes and scorer state encoding
//               for the Wordle scorer and any display logic that reads its
//               score. Letter position 0 is the leftmost letter (word
//               bits [39:32], score bits [9:8]).
// Revision    : 1.0 - initial release
// ============================================================================
package wordle_scorer_pkg;

    localparam int LETTERS = 5;
    localparam int WORD_W  = 8 * LETTERS;
    localparam int SCORE_W = 2 * LETTERS;

    // Per-letter colour codes; 2'b11 is never produced.
    localparam logic [1:0] GREY   = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] GREEN  = 2'b10;

    localparam logic [SCORE_W-1:0] c_all_green = {LETTERS{GREEN}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GREEN = 2'd1,
        ST_YEL   = 2'd2,
        ST_DONE  = 2'd3
    } scorer_state_t;

    // Byte of a packed word at letter position pos (0 = leftmost).
    function automatic logic [7:0] get_letter(input logic [WORD_W-1:0] word,
                                              input logic [2:0]        pos);
        get_letter = 8'h00;
        for (int p = 0; p < LETTERS; p++) begin
            if (pos == 3'(p)) get_letter = word[WORD_W-1-8*p -: 8];
        end
    endfunction

    // Colour field of a packed score at letter position pos (0 = leftmost).
    function automatic logic [1:0] get_colour(input logic [SCORE_W-1:0] sc,
                                              input logic [2:0]         pos);
        get_colour = GREY;
        for (int p = 0; p < LETTERS; p++) begin
            if (pos == 3'(p)) get_colour = sc[SCORE_W-1-2*p -: 2];
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/wordle_match_finder.sv
`default_nettype none
// ============================================================================
// Module      : wordle_match_finder
// Description : Combinational search for the leftmost answer position that
//               holds a given letter and has not yet been consumed.
//   i_letter  in  8   letter to look for
//   i_answer  in  40  answer word, position 0 in the top byte
//   i_used    in  5   bit p set = answer position p already consumed
//   o_found   out 1   at least one free matching position exists
//   o_onehot  out 5   bit p set for the leftmost free matching position
// Revision    : 1.0 - initial release
// ============================================================================
module wordle_match_finder
    import wordle_scorer_pkg::*;
(
    input  logic [7:0]         i_letter,
    input  logic [WORD_W-1:0]  i_answer,
    input  logic [LETTERS-1:0] i_used,
    output logic               o_found,
    output logic [LETTERS-1:0] o_onehot
);

    logic [LETTERS-1:0] w_hit;

    for (genvar p = 0; p < LETTERS; p++) begin : g_hit
        assign w_hit[p] = (i_answer[WORD_W-1-8*p -: 8] == i_letter) && !i_used[p];
    end

    // Bit 0 is the leftmost position, so isolating the lowest set bit gives
    // the lowest-numbered match.
    assign o_onehot = w_hit & (~w_hit + 1'b1);
    assign o_found  = |w_hit;

endmodule
`default_nettype wire

// File: rtl/wordle_scorer.sv
`default_nettype none
// ============================================================================
// Module      : wordle_scorer
// Description : Scores one five-letter guess against the answer using the
//               Wordle rules: exact matches first (green), then a left-to-
//               right pass handing out yellows from the answer letters that
//               are still unused. Fixed 7-edge latency from Start to Done.
//   Clk      in  1   clock, rising edge
//   reset_n  in  1   asynchronous active-low reset
//   Start    in  1   begin scoring; only looked at while idle
//   guess    in  40  guess word, position 1 in [39:32]
//   answer   in  40  answer word, same packing
//   Busy     out 1   scoring in progress
//   Done     out 1   one-cycle pulse, score/win valid from this cycle
//   score    out 10  2 bits per position, position 1 in [9:8]
//   win      out 1   all five positions green
// Revision    : 1.0 - initial release
// ============================================================================
module wordle_scorer
    import wordle_scorer_pkg::*;
(
    input  logic               Clk,
    input  logic               reset_n,
    input  logic               Start,
    input  logic [WORD_W-1:0]  guess,
    input  logic [WORD_W-1:0]  answer,
    output logic               Busy,
    output logic               Done,
    output logic [SCORE_W-1:0] score,
    output logic               win
);

    scorer_state_t      r_state;
    scorer_state_t      w_state_nxt;
    logic [2:0]         r_idx;
    logic [LETTERS-1:0] r_used;
    logic [SCORE_W-1:0] r_score;
    logic               r_win;
    logic               r_done;
    logic [WORD_W-1:0]  r_guess;
    logic [WORD_W-1:0]  r_answer;

    logic [7:0]         w_cur_letter;
    logic               w_cur_green;
    logic               w_found;
    logic [LETTERS-1:0] w_onehot;

    assign w_cur_letter = get_letter(r_guess, r_idx);
    assign w_cur_green  = (get_colour(r_score, r_idx) == GREEN);

    wordle_match_finder u_finder (
        .i_letter (w_cur_letter),
        .i_answer (r_answer),
        .i_used   (r_used),
        .o_found  (w_found),
        .o_onehot (w_onehot)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (Start) w_state_nxt = ST_GREEN;
            ST_GREEN: w_state_nxt = ST_YEL;
            ST_YEL:   if (r_idx == 3'(LETTERS-1)) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx    <= '0;
            r_used   <= '0;
            r_score  <= '0;
            r_win    <= 1'b0;
            r_done   <= 1'b0;
            r_guess  <= '0;
            r_answer <= '0;
        end else begin
            // Done is registered off the DONE state, so it rises on the edge
            // that leaves DONE - the 7th edge after Start was sampled.
            r_done <= (r_state == ST_DONE);
            case (r_state)
                ST_IDLE: begin
                    if (Start) begin
                        r_guess  <= guess;
                        r_answer <= answer;
                        r_score  <= '0;
                        r_win    <= 1'b0;
                        r_used   <= '0;
                        r_idx    <= '0;
                    end
                end
                ST_GREEN: begin
                    for (int p = 0; p < LETTERS; p++) begin
                        if (r_guess[WORD_W-1-8*p -: 8] == r_answer[WORD_W-1-8*p -: 8]) begin
                            r_score[SCORE_W-1-2*p -: 2] <= GREEN;
                            r_used[p]                   <= 1'b1;
                        end
                    end
                    r_idx <= '0;
                end
                ST_YEL: begin
                    // Greens already own their answer letter; only non-green
                    // positions may consume a free one.
                    if (!w_cur_green && w_found) begin
                        r_used <= r_used | w_onehot;
                        for (int p = 0; p < LETTERS; p++) begin
                            if (r_idx == 3'(p)) r_score[SCORE_W-1-2*p -: 2] <= YELLOW;
                        end
                    end
                    r_idx <= r_idx + 3'd1;
                end
                ST_DONE: begin
                    r_win <= (r_score == c_all_green);
                end
                default: ;
            endcase
        end
    end

    assign Busy  = (r_state == ST_GREEN) || (r_state == ST_YEL);
    assign Done  = r_done;
    assign score = r_score;
    assign win   = r_win;

endmodule
`default_nettype wire

// File: tb/tb_wordle_scorer.sv
`default_nettype none
// ============================================================================
// Module      : tb_wordle_scorer
// Description : Self-checking bench for wordle_scorer. Directed words plus
//               random words, checked against a letter-count reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wordle_scorer;

    logic        Clk = 1'b0;
    logic        reset_n;
    logic        Start;
    logic [39:0] guess;
    logic [39:0] answer;
    logic        Busy;
    logic        Done;
    logic [9:0]  score;
    logic        win;

    int n_vec = 0;
    int n_err = 0;

    wordle_scorer dut (
        .Clk     (Clk),
        .reset_n (reset_n),
        .Start   (Start),
        .guess   (guess),
        .answer  (answer),
        .Busy    (Busy),
        .Done    (Done),
        .score   (score),
        .win     (win)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: greens first, then each remaining guess letter (left to
    // right) takes yellow while the answer still has an unmatched copy.
    function automatic void model(input logic [39:0] g, input logic [39:0] a,
                                  output logic [9:0] sc, output logic w);
        int         cnt[256];
        int         col[5];
        logic [7:0] gl[5];
        logic [7:0] al[5];
        foreach (cnt[i]) cnt[i] = 0;
        for (int i = 0; i < 5; i++) begin
            gl[i] = g[39-8*i -: 8];
            al[i] = a[39-8*i -: 8];
            col[i] = 0;
        end
        for (int i = 0; i < 5; i++) begin
            if (gl[i] == al[i]) col[i] = 2;
            else                cnt[al[i]]++;
        end
        for (int i = 0; i < 5; i++) begin
            if (col[i] != 2 && cnt[gl[i]] > 0) begin
                col[i] = 1;
                cnt[gl[i]]--;
            end
        end
        sc = '0;
        w  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sc[9-2*i -: 2] = 2'(col[i]);
            if (col[i] != 2) w = 1'b0;
        end
    endfunction

    function automatic logic [39:0] rand_word(input bit wide);
        logic [39:0] wd;
        for (int i = 0; i < 5; i++) begin
            if (wide) wd[39-8*i -: 8] = 8'($urandom_range(0, 255));
            else      wd[39-8*i -: 8] = 8'("A" + $urandom_range(0, 3));
        end
        return wd;
    endfunction

    // Called just after a rising edge. Runs one operation and checks clear,
    // Busy, latency, result, Done pulse width and result hold. With disturb
    // set, Start is re-pulsed and guess scrambled while the op is running.
    task automatic run_op(input string name, input logic [39:0] g, input logic [39:0] a,
                          input bit disturb);
        logic [9:0] exp_sc;
        logic       exp_w;
        int         lat;
        int         extra;
        model(g, a, exp_sc, exp_w);
        guess  = g;
        answer = a;
        Start  = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        check({name, " clr_score"}, 64'(score), 64'h0);
        check({name, " clr_win"},   64'(win),   64'h0);
        check({name, " busy"},      64'(Busy),  64'h1);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            if (disturb && k <= 7) begin
                Start  = 1'b1;
                guess  = rand_word(1'b0);
                answer = rand_word(1'b0);
            end else begin
                Start = 1'b0;
            end
            @(posedge Clk); #1;
            if (Done) begin
                lat = k;
                break;
            end
        end
        Start = 1'b0;
        check({name, " latency"}, 64'(lat), 64'd7);
        if (lat != 0) begin
            check({name, " score"},  64'(score), 64'(exp_sc));
            check({name, " win"},    64'(win),   64'(exp_w));
            check({name, " idle"},   64'(Busy),  64'h0);
        end
        extra = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge Clk); #1;
            if (Done) extra++;
        end
        check({name, " one_done"},   64'(extra), 64'd0);
        check({name, " hold_score"}, 64'(score), 64'(exp_sc));
        check({name, " hold_win"},   64'(win),   64'(exp_w));
    endtask

    initial begin
        reset_n = 1'b0;
        Start   = 1'b0;
        guess   = '0;
        answer  = '0;
        repeat (2) @(posedge Clk);
        #1;
        check("rst score", 64'(score), 64'h0);
        check("rst win",   64'(win),   64'h0);
        check("rst done",  64'(Done),  64'h0);
        check("rst busy",  64'(Busy),  64'h0);
        @(negedge Clk);
        reset_n = 1'b1;
        @(posedge Clk); #1;

        run_op("crane", "CRANE", "CRANE", 1'b0);
        check("crane const", 64'(score), 64'h2AA);
        check("crane winc",  64'(win),   64'h1);
        run_op("boost", "BOOST", "ROBOT", 1'b0);
        check("boost const", 64'(score), 64'h192);
        run_op("bbbbb", "BBBBB", "ABBOT", 1'b0);
        check("bbbbb const", 64'(score), 64'h0A0);
        run_op("aaaaa", "AAAAA", "CACAO", 1'b0);
        check("aaaaa const", 64'(score), 64'h088);
        check("aaaaa winc",  64'(win),   64'h0);

        run_op("disturb", "BOOST", "ROBOT", 1'b1);
        check("disturb const", 64'(score), 64'h192);

        // Reset in the middle of YEL with greens already in score.
        guess   = "CRANE";
        answer  = "CRANE";
        Start   = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (3) @(posedge Clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("midrst score", 64'(score), 64'h0);
        check("midrst busy",  64'(Busy),  64'h0);
        check("midrst done",  64'(Done),  64'h0);
        check("midrst win",   64'(win),   64'h0);
        @(negedge Clk);
        reset_n = 1'b1;
        @(posedge Clk); #1;
        check("postrst done", 64'(Done), 64'h0);
        run_op("robot", "ROBOT", "ROBOT", 1'b0);
        check("robot const", 64'(score), 64'h2AA);

        for (int t = 0; t < 40; t++) begin
            logic [39:0] g;
            logic [39:0] a;
            bit          wide;
            wide = ($urandom_range(0, 4) == 0);
            a = rand_word(wide);
            g = ($urandom_range(0, 5) == 0) ? a : rand_word(wide);
            run_op($sformatf("rnd%0d", t), g, a, ($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/wordle_scorer.md
WORDLE_SCORER -- requirements
Module: wordle_scorer

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset; the ports are listed below, clock and reset first.
REQ-002 Clk  in  1  system clock; all state changes on its rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 Start  in  1  request to score the current guess; sampled only in IDLE.
REQ-005 guess  in  40  five 8-bit ASCII letters; [39:32] is position 1 and [7:0] is position 5.
REQ-006 answer  in  40  word of the day, same packing as guess.
REQ-007 Busy  out  1  high while a scoring operation is in progress.
REQ-008 Done  out  1  one-cycle pulse; score and win are valid from this cycle on.
REQ-009 score  out  10  2 bits per position; [9:8] is position 1; 00 grey, 01 yellow, 10 green; 11 is never driven.
REQ-010 win  out  1  high when all five positions are green; held with score.

Function
REQ-011 States SHALL be IDLE, GREEN, YEL, DONE, with a 3-bit index idx used in YEL.
REQ-012 IDLE with Start=1 SHALL capture guess and answer into internal registers, clear score, and go to GREEN; IDLE with Start=0 SHALL hold.
REQ-013 GREEN SHALL, per position p, set score[p]=10 when guess[p]==answer[p] (exact 8-bit compare) and mark answer[p] as used; idx is cleared to 0 and the state goes to YEL.
REQ-014 Each YEL cycle SHALL handle guess position idx as follows:
- If score[idx] is not green, the lowest-numbered unused answer position q with answer[q]==guess[idx] becomes used and score[idx]=01.
- If no such q exists, score[idx] stays 00.
REQ-015 YEL SHALL increment idx each cycle and go to DONE after idx=4 is handled, giving exactly 5 YEL cycles.
REQ-016 DONE SHALL assert Done for exactly one cycle, set win=(score==10'h2AA), and return to IDLE.
REQ-017 Latency SHALL be fixed: Done is high in the cycle following the 7th rising edge after the edge that sampled Start.
REQ-018 Busy SHALL be 1 in GREEN and YEL and 0 in IDLE and DONE.
REQ-019 Start SHALL be ignored outside IDLE; a Start in the DONE cycle is not queued.
REQ-020 guess and answer changing after capture SHALL have no effect on the running operation.
REQ-021 score and win SHALL hold their values after DONE until the next accepted Start, which clears them.
REQ-022 Non-letter bytes SHALL be compared as plain bytes, with no validation.

Reset
REQ-023 reset_n=0 SHALL immediately force the following, including in the middle of an operation, and no Done is emitted for an aborted operation:
- state=IDLE, idx=0, used flags=0, score=0;
- win=0, Done=0, Busy=0;
- captured word registers=0.
REQ-024 After reset_n is released, the first Start SHALL be accepted on the first rising edge at which it is sampled high.

Structure
REQ-025 A shared package SHALL hold the following, for use by the guess state machine and by display logic:
- LETTERS=5, WORD_W=40;
- colour codes GREY/YELLOW/GREEN;
- the scorer state encoding.
REQ-026 One combinational sub-module, wordle_match_finder, SHALL be used:
- inputs: one letter, the answer word, 5-bit used mask;
- outputs: found and a 5-bit one-hot position (lowest index wins).

Verification
REQ-027 Exact match: answer "CRANE", guess "CRANE", Start -> Done 7 edges later, score=10'h2AA, win=1.
REQ-028 Mixed: answer "ROBOT", guess "BOOST" -> score=10'h192 (Y,G,Y,Gr,G), win=0.
REQ-029 Duplicates already consumed: answer "ABBOT", guess "BBBBB" -> score=10'h0A0; no yellow is given for extra B's.
REQ-030 Repeated letter: answer "CACAO", guess "AAAAA" -> score=10'h088, win=0.
REQ-031 Start pulsed during Busy and guess changed mid-operation -> exactly one Done, with the result for the originally captured guess.
REQ-032 reset_n low during YEL -> outputs are 0 immediately; a following Start with "ROBOT"/"ROBOT" -> score=10'h2AA.
